// File: rtl/iq_stream_packer.sv
// -----------------------------------------------------------------------------
// iq_stream_packer
//
// Snapshots N_CH decimated I/Q channel pairs on each accepted strobe and
// serialises them into MIN-style framed byte packets:
//   AA AA AA | ID | LEN | [SEQ] | payload (big-endian) | CHK
// with a 0x55 stuff byte after every two consecutive 0xAA body bytes.
// A one-deep pending buffer absorbs one strobe while a frame is on the wire;
// further strobes are dropped and counted.
//
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_en             capture enable (gates strobe acceptance only)
//   i_strobe         single-cycle decimated-sample strobe
//   i_data           samples, MSB-first: ch0 I, ch0 Q, ch1 I, ...
//   i_ready          downstream can take a byte
//   o_data/o_valid   byte stream; a byte transfers on o_valid && i_ready
//   o_busy           frame in progress or pending
//   o_overrun        sticky: at least one frame dropped since reset
//   o_drop_count     dropped-frame count, saturating at 255
// -----------------------------------------------------------------------------
module iq_stream_packer #(
  parameter int         N_CH         = 2,
  parameter int         SAMPLE_WIDTH = 16,
  parameter logic [7:0] PACKET_ID    = 8'h01,
  parameter bit         SEQ_EN       = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic                           i_strobe,
  input  logic [N_CH*2*SAMPLE_WIDTH-1:0] i_data,
  input  logic                           i_ready,
  output logic [7:0]                     o_data,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_overrun,
  output logic [7:0]                     o_drop_count
);

  localparam int         DW        = N_CH * 2 * SAMPLE_WIDTH;
  localparam int         PAY_BYTES = DW / 8;
  localparam int         LEN       = PAY_BYTES + (SEQ_EN ? 1 : 0);
  localparam logic [7:0] LEN_BYTE  = 8'(LEN);
  localparam logic [7:0] LAST_PAY  = 8'(PAY_BYTES - 1);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("iq_stream_packer: N_CH must be 1..16");
  end
  if (SAMPLE_WIDTH != 8 && SAMPLE_WIDTH != 16 &&
      SAMPLE_WIDTH != 24 && SAMPLE_WIDTH != 32) begin : g_bad_sw
    $error("iq_stream_packer: SAMPLE_WIDTH must be 8, 16, 24 or 32");
  end
  if (LEN > 255) begin : g_bad_len
    $error("iq_stream_packer: frame length exceeds 255");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ID, S_LEN, S_SEQ, S_PAY, S_CHK, S_STUFF
  } state_e;

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;           // state to resume after STUFF
  logic [7:0]      idx_q, idx_d;           // header / payload byte index
  logic [7:0]      sum_q, sum_d;           // running checksum sum
  logic            aa_q, aa_d;             // previous body byte was 0xAA
  logic [7:0]      seq_q, seq_d;
  logic            pend_full_q, pend_full_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      drop_q, drop_d;
  logic [DW-1:0]   act_q, act_d;           // shifts left as payload goes out
  logic [DW-1:0]   pend_q, pend_d;
  logic [7:0]      act_seq_q, act_seq_d;
  logic [7:0]      pend_seq_q, pend_seq_d;

  logic            xfer;
  logic            acc;
  logic            free_slot;
  logic            have_next;
  state_e          end_state;

  assign xfer = (state_q != S_IDLE) && i_ready;
  assign acc  = i_strobe && i_en;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      aa_q        <= 1'b0;
      seq_q       <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      aa_q        <= aa_d;
      seq_q       <= seq_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
    end
  end

  // NOTE: sample buffers carry no reset; they are only read after being
  // loaded, and the valid/full flags that qualify them are reset.
  always_ff @(posedge i_clk) begin
    act_q      <= act_d;
    pend_q     <= pend_d;
    act_seq_q  <= act_seq_d;
    pend_seq_q <= pend_seq_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    aa_d        = aa_q;
    seq_d       = seq_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q;
    drop_d      = drop_q;
    act_d       = act_q;
    pend_d      = pend_q;
    act_seq_d   = act_seq_q;
    pend_seq_d  = pend_seq_q;
    have_next   = 1'b0;

    // Sequence numbers are consumed by every accepted strobe, dropped or not.
    if (acc) seq_d = seq_q + 8'd1;

    // The active buffer becomes free when idle, when CHK goes out, or when a
    // trailing stuff byte after CHK goes out. The pending slot is freed at the
    // same moment, so a strobe arriving then is never dropped.
    free_slot = (state_q == S_IDLE) ||
                (xfer && (state_q == S_CHK ||
                          (state_q == S_STUFF && ret_q == S_IDLE)));

    if (free_slot) begin
      if (pend_full_q) begin
        act_d       = pend_q;
        act_seq_d   = pend_seq_q;
        have_next   = 1'b1;
        pend_full_d = acc;
        if (acc) begin
          pend_d     = i_data;
          pend_seq_d = seq_q;
        end
      end else if (acc) begin
        act_d     = i_data;
        act_seq_d = seq_q;
        have_next = 1'b1;
      end
    end else if (acc) begin
      if (!pend_full_q) begin
        pend_d      = i_data;
        pend_seq_d  = seq_q;
        pend_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end

    end_state = have_next ? S_HDR : S_IDLE;

    unique case (state_q)
      S_IDLE: begin
        if (have_next) begin
          state_d = S_HDR;
          idx_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (idx_q == 8'd2) begin
            state_d = S_ID;
            idx_d   = '0;
            aa_d    = 1'b0;
            sum_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_ID: begin
        if (xfer) begin
          sum_d   = sum_q + o_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          sum_d   = sum_q + o_data;
          state_d = SEQ_EN ? S_SEQ : S_PAY;
        end
      end
      S_SEQ: begin
        if (xfer) begin
          sum_d   = sum_q + o_data;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (xfer) begin
          sum_d = sum_q + o_data;
          act_d = {act_q[DW-9:0], 8'h00};
          if (idx_q == LAST_PAY) begin
            state_d = S_CHK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_d = end_state;
          idx_d   = '0;
        end
      end
      S_STUFF: begin
        if (xfer) begin
          if (ret_q == S_IDLE) begin
            state_d = end_state;
            idx_d   = '0;
          end else begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stuffing overlays the body states: a second consecutive 0xAA diverts
    // to STUFF, remembering where the frame would have gone.
    if (xfer && (state_q == S_ID || state_q == S_LEN || state_q == S_SEQ ||
                 state_q == S_PAY || state_q == S_CHK)) begin
      if (o_data == 8'hAA) begin
        if (aa_q) begin
          ret_d   = state_d;
          state_d = S_STUFF;
          aa_d    = 1'b0;
        end else begin
          aa_d = 1'b1;
        end
      end else begin
        aa_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    o_valid      = (state_q != S_IDLE);
    o_busy       = (state_q != S_IDLE) || pend_full_q;
    o_overrun    = overrun_q;
    o_drop_count = drop_q;
    o_data       = 8'h00;
    unique case (state_q)
      S_IDLE:  o_data = 8'h00;
      S_HDR:   o_data = 8'hAA;
      S_ID:    o_data = PACKET_ID;
      S_LEN:   o_data = LEN_BYTE;
      S_SEQ:   o_data = act_seq_q;
      S_PAY:   o_data = act_q[DW-1 -: 8];
      S_CHK:   o_data = 8'h00 - sum_q;
      S_STUFF: o_data = 8'h55;
      default: o_data = 8'h00;
    endcase
  end

endmodule
